// File: rtl/yd_uart_pkg.sv
// yd_uart shared definitions: register map, STATUS bit positions,
// FSM state type and divider floor.
package yd_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  localparam int unsigned STB_TX_BUSY   = 0;
  localparam int unsigned STB_RX_VALID  = 1;
  localparam int unsigned STB_OVERRUN   = 2;
  localparam int unsigned STB_FRAME_ERR = 3;
  localparam int unsigned STB_RX_IE     = 4;
  localparam int unsigned STB_TX_IE     = 5;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Divider actually used by a frame: BAUDDIV clamped to DIV_MIN.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/yd_uart_fifo.sv
// yd_uart_fifo: 4x8 synchronous FIFO used as the RX holding store when
// YD_UART_RX_FIFO_EN is defined. A push while full is accepted only if a
// pop happens in the same cycle.
module yd_uart_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  logic [7:0] r_mem [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_cnt;
  logic       w_do_pop;
  logic       w_do_push;

  assign empty     = (r_cnt == 3'd0);
  assign full      = (r_cnt == 3'd4);
  assign dout      = r_mem[r_rp];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 2'd1;
      if (w_do_pop)  r_rp <= r_rp + 2'd1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/yd_uart.sv
// yd_uart: memory-mapped UART slave (TXDATA/RXDATA/STATUS/BAUDDIV).
// Optional 4-deep RX FIFO when macro YD_UART_RX_FIFO_EN is defined.
module yd_uart
  import yd_uart_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'hFF10,
  parameter logic [15:0] DIV_RST = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  output logic [15:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        int_vld
);

  logic        w_sel, w_wr_tx, w_wr_rx, w_wr_st, w_wr_bd;
  logic [15:0] r_baud;
  logic        r_rx_ie, r_tx_ie, r_ovr, r_ferr;

  uart_state_t r_tx_st;
  logic [15:0] r_tx_div, r_tx_cnt;
  logic [7:0]  r_tx_sh;
  logic [2:0]  r_tx_bit;
  logic        r_txd, w_tx_busy;

  uart_state_t r_rx_st;
  logic [15:0] r_rx_div, r_rx_cnt;
  logic [7:0]  r_rx_sh;
  logic [2:0]  r_rx_bit;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        w_rx_stop_smp, w_rx_done, w_rx_ferr, w_ovr_set;
  logic        w_rx_valid;
  logic [7:0]  w_rx_byte;

  assign w_sel   = (addr[15:2] == BASE[15:2]);
  assign w_wr_tx = w_sel & we & (addr[1:0] == REG_TXDATA);
  assign w_wr_rx = w_sel & we & (addr[1:0] == REG_RXDATA);
  assign w_wr_st = w_sel & we & (addr[1:0] == REG_STATUS);
  assign w_wr_bd = w_sel & we & (addr[1:0] == REG_BAUDDIV);

  assign w_tx_busy = (r_tx_st != IDLE);
  assign txd       = r_txd;
  assign int_vld   = (r_rx_ie & w_rx_valid) | (r_tx_ie & ~w_tx_busy);

  // TX FSM: counters run 1..div so each state/bit lasts exactly div cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st  <= IDLE;
      r_tx_div <= DIV_MIN;
      r_tx_cnt <= '0;
      r_tx_sh  <= '0;
      r_tx_bit <= '0;
      r_txd    <= 1'b1;
    end else begin
      case (r_tx_st)
        IDLE: if (w_wr_tx) begin
          r_tx_st  <= START;
          r_tx_div <= eff_div(r_baud);
          r_tx_cnt <= 16'd1;
          r_tx_sh  <= wdata[7:0];
          r_txd    <= 1'b0;
        end
        START: if (r_tx_cnt == r_tx_div) begin
          r_tx_st  <= DATA;
          r_tx_cnt <= 16'd1;
          r_tx_bit <= '0;
          r_txd    <= r_tx_sh[0];
        end else r_tx_cnt <= r_tx_cnt + 16'd1;
        DATA: if (r_tx_cnt == r_tx_div) begin
          r_tx_cnt <= 16'd1;
          if (r_tx_bit == 3'd7) begin
            r_tx_st <= STOP;
            r_txd   <= 1'b1;
          end else begin
            r_tx_bit <= r_tx_bit + 3'd1;
            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
            r_txd    <= r_tx_sh[1];
          end
        end else r_tx_cnt <= r_tx_cnt + 16'd1;
        STOP: if (r_tx_cnt == r_tx_div) r_tx_st <= IDLE;
              else r_tx_cnt <= r_tx_cnt + 16'd1;
        default: r_tx_st <= IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus one history flop for falling-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX FSM: counter holds cycles since the detected edge, so the start
  // check lands div/2 after it and each later sample div after the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_st  <= IDLE;
      r_rx_div <= DIV_MIN;
      r_rx_cnt <= '0;
      r_rx_sh  <= '0;
      r_rx_bit <= '0;
    end else begin
      case (r_rx_st)
        IDLE: if (r_rx_prev & ~r_rx_s2) begin
          r_rx_st  <= START;
          r_rx_div <= eff_div(r_baud);
          r_rx_cnt <= 16'd1;
        end
        START: if (r_rx_cnt == {1'b0, r_rx_div[15:1]}) begin
          if (r_rx_s2) r_rx_st <= IDLE;
          else begin
            r_rx_st  <= DATA;
            r_rx_cnt <= 16'd1;
            r_rx_bit <= '0;
          end
        end else r_rx_cnt <= r_rx_cnt + 16'd1;
        DATA: if (r_rx_cnt == r_rx_div) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_cnt <= 16'd1;
          if (r_rx_bit == 3'd7) r_rx_st <= STOP;
          else r_rx_bit <= r_rx_bit + 3'd1;
        end else r_rx_cnt <= r_rx_cnt + 16'd1;
        STOP: if (r_rx_cnt == r_rx_div) r_rx_st <= IDLE;
              else r_rx_cnt <= r_rx_cnt + 16'd1;
        default: r_rx_st <= IDLE;
      endcase
    end
  end

  assign w_rx_stop_smp = (r_rx_st == STOP) && (r_rx_cnt == r_rx_div);
  assign w_rx_done     = w_rx_stop_smp & r_rx_s2;
  assign w_rx_ferr     = w_rx_stop_smp & ~r_rx_s2;

`ifdef YD_UART_RX_FIFO_EN
  logic w_fifo_empty, w_fifo_full;

  assign w_ovr_set  = w_rx_done & w_fifo_full & ~w_wr_rx;
  assign w_rx_valid = ~w_fifo_empty;

  yd_uart_fifo u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_done),
    .pop   (w_wr_rx),
    .din   (r_rx_sh),
    .dout  (w_rx_byte),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );
`else
  logic       r_rx_valid;
  logic [7:0] r_rx_byte;

  assign w_ovr_set  = w_rx_done & r_rx_valid & ~w_wr_rx;
  assign w_rx_valid = r_rx_valid;
  assign w_rx_byte  = r_rx_byte;

  // Holding register; a completion coinciding with an RXDATA write stores
  // the new byte instead of clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_valid <= 1'b0;
      r_rx_byte  <= '0;
    end else if (w_rx_done && (!r_rx_valid || w_wr_rx)) begin
      r_rx_valid <= 1'b1;
      r_rx_byte  <= r_rx_sh;
    end else if (w_wr_rx) begin
      r_rx_valid <= 1'b0;
    end
  end
`endif

  // Control registers and sticky error flags (set beats W1C).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud  <= DIV_RST;
      r_rx_ie <= 1'b0;
      r_tx_ie <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_wr_bd) r_baud <= wdata;
      if (w_wr_st) begin
        r_rx_ie <= wdata[STB_RX_IE];
        r_tx_ie <= wdata[STB_TX_IE];
      end
      r_ovr  <= w_ovr_set | (r_ovr  & ~(w_wr_st & wdata[STB_OVERRUN]));
      r_ferr <= w_rx_ferr | (r_ferr & ~(w_wr_st & wdata[STB_FRAME_ERR]));
    end
  end

  // Combinational read mux, zero when not selected.
  always_comb begin
    rdata = '0;
    if (w_sel) begin
      case (addr[1:0])
        REG_RXDATA:  rdata = {8'h00, w_rx_byte};
        REG_STATUS: begin
          rdata[STB_TX_BUSY]   = w_tx_busy;
          rdata[STB_RX_VALID]  = w_rx_valid;
          rdata[STB_OVERRUN]   = r_ovr;
          rdata[STB_FRAME_ERR] = r_ferr;
          rdata[STB_RX_IE]     = r_rx_ie;
          rdata[STB_TX_IE]     = r_tx_ie;
        end
        REG_BAUDDIV: rdata = r_baud;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_yd_uart.sv
// Self-checking bench for yd_uart; adapts its RX model depth to
// YD_UART_RX_FIFO_EN.
module tb_yd_uart;

`ifdef YD_UART_RX_FIFO_EN
  localparam int unsigned RXQ_DEPTH = 4;
`else
  localparam int unsigned RXQ_DEPTH = 1;
`endif

  localparam logic [15:0] A_TX = 16'hFF10;
  localparam logic [15:0] A_RX = 16'hFF11;
  localparam logic [15:0] A_ST = 16'hFF12;
  localparam logic [15:0] A_BD = 16'hFF13;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata;
  logic        rxd;
  logic        txd;
  logic        int_vld;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model of the RX side: byte queue plus flag bits.
  logic [7:0] rxq[$];
  logic       m_ovr, m_ferr, m_rxie, m_txie;

  yd_uart #(.BASE(16'hFF10), .DIV_RST(16'd104)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .rxd     (rxd),
    .txd     (txd),
    .int_vld (int_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    addr = a; we = 1'b0;
    #1 d = rdata;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[1] = (rxq.size() != 0);
    s[2] = m_ovr;
    s[3] = m_ferr;
    s[4] = m_rxie;
    s[5] = m_txie;
    return s;
  endfunction

  function automatic logic m_int();
    return (m_rxie && rxq.size() != 0) || m_txie;
  endfunction

  task automatic model_reset();
    rxq.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_rxie = 1'b0; m_txie = 1'b0;
  endtask

  // Transmit one frame, checking txd and tx_busy every cycle; optionally
  // pokes TXDATA and BAUDDIV mid-frame, which must not disturb it.
  task automatic tx_frame(input logic [7:0] b, input logic [15:0] dw, input bit inject);
    int unsigned eff;
    logic [9:0]  frame;
    logic [15:0] st;
    eff   = (dw < 16'd4) ? 4 : int'(dw);
    frame = {1'b1, b, 1'b0};
    bus_write(A_BD, dw);
    bus_write(A_TX, {8'h00, b});
    for (int i = 0; i <= 10 * int'(eff); i++) begin
      if (i > 0) @(negedge clk);
      we = 1'b0;
      bus_read(A_ST, st);
      check("txd", {15'b0, txd}, (i < 10 * int'(eff)) ? {15'b0, frame[i / int'(eff)]} : 16'd1);
      check("tx_busy", {15'b0, st[0]}, (i < 10 * int'(eff)) ? 16'd1 : 16'd0);
      if (inject && i == 20) begin addr = A_TX; wdata = {8'h00, ~b}; we = 1'b1; end
      if (inject && i == 40) begin addr = A_BD; wdata = 16'd5; we = 1'b1; end
    end
    we = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int unsigned div);
    rxd = 1'b0; tick(div);
    for (int k = 0; k < 8; k++) begin rxd = b[k]; tick(div); end
    rxd = stop; tick(div);
    rxd = 1'b1; tick(2);
    if (!stop) m_ferr = 1'b1;
    else if (rxq.size() < RXQ_DEPTH) rxq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic rx_check(input string tag);
    logic [15:0] d;
    bus_read(A_ST, d);
    check({tag, "_status"}, d, m_status());
    check({tag, "_int"}, {15'b0, int_vld}, {15'b0, m_int()});
    if (rxq.size() != 0) begin
      bus_read(A_RX, d);
      check({tag, "_rxdata"}, d, {8'h00, rxq[0]});
    end
  endtask

  task automatic rx_pop(input string tag);
    bus_write(A_RX, 16'h0000);
    if (rxq.size() != 0) void'(rxq.pop_front());
    rx_check(tag);
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  b;
    int unsigned n;
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; rxd = 1'b1;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state.
    check("rst_txd", {15'b0, txd}, 16'd1);
    check("rst_int", {15'b0, int_vld}, 16'd0);
    bus_read(A_BD, d); check("rst_bauddiv", d, 16'd104);
    bus_read(A_ST, d); check("rst_status", d, 16'h0000);
    bus_read(16'hFF14, d); check("unsel_rdata", d, 16'h0000);
    bus_read(A_TX, d); check("txdata_reads0", d, 16'h0000);

    // TX: directed A5 at div 8 with ignored mid-frame writes, then random.
    tx_frame(8'hA5, 16'd8, 1'b1);
    tx_frame(8'($urandom), 16'($urandom_range(0, 3)), 1'b0);
    tx_frame(8'($urandom), 16'($urandom_range(4, 11)), 1'b0);

    // tx_ie alone raises int_vld while transmitter idle.
    bus_write(A_ST, 16'h0020); m_txie = 1'b1;
    check("tx_ie_int", {15'b0, int_vld}, 16'd1);
    bus_write(A_ST, 16'h0000); m_txie = 1'b0;

    // Reset mid-frame.
    bus_write(A_BD, 16'd8);
    bus_write(A_TX, 16'h0000);
    tick(15);
    rst = 1'b1; tick(1); rst = 1'b0;
    model_reset();
    check("midrst_txd", {15'b0, txd}, 16'd1);
    bus_read(A_ST, d); check("midrst_status", d, 16'h0000);
    bus_read(A_BD, d); check("midrst_bauddiv", d, 16'd104);

    // RX basic receive with rx_ie.
    bus_write(A_BD, 16'd8);
    bus_write(A_ST, 16'h0010); m_rxie = 1'b1;
    rx_send(8'h3C, 1'b1, 8);
    rx_check("rx3c");
    rx_pop("rx3c_clr");

    // Five bytes 01..05 without reading: overrun / FIFO fill.
    for (int j = 1; j <= 5; j++) begin
      rx_send(8'(j), 1'b1, 8);
      tick(3);
      rx_check("rx5");
    end
    bus_write(A_ST, 16'h0014); m_ovr = 1'b0;
    rx_check("ovr_w1c");
    for (int j = 0; j < 5 && rxq.size() != 0; j++) rx_pop("drain5");

    // Random bytes with random gaps.
    n = $urandom_range(3, 6);
    for (int j = 0; j < int'(n); j++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1, 8);
      tick($urandom_range(1, 6));
      rx_check("rxrand");
    end
    bus_write(A_ST, 16'h0014); m_ovr = 1'b0;
    for (int j = 0; j < 5 && rxq.size() != 0; j++) rx_pop("drainr");

    // Frame error: stop bit low.
    rx_send(8'($urandom), 1'b0, 8);
    tick(3);
    rx_check("frame_err");
    bus_write(A_ST, 16'h0018); m_ferr = 1'b0;
    rx_check("ferr_w1c");

    // Two-cycle glitch must leave no trace; a following byte still arrives.
    rxd = 1'b0; tick(2); rxd = 1'b1; tick(40);
    rx_check("glitch");
    b = 8'($urandom);
    rx_send(b, 1'b1, 8);
    rx_check("post_glitch");
    rx_pop("post_glitch_clr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/yd_uart.md
# yd_uart

Memory-mapped UART responder on the SoC data bus, the slave side of the core's data-bus protocol. Decodes a 4-word window, holds the baud divider, serializes bytes written by the core onto `txd` and deserializes `rxd` into a readable holding register. Raises a level interrupt request toward the interrupt aggregation in the data-bus fabric. Instantiated beside the GPIO/PWM peripherals; its `rdata` is OR-ed into the bus read mux.

## Interface
- `BASE`, 16'hFF10, word-aligned window base; the block is selected when `addr[15:2] == BASE[15:2]`
- `DIV_RST`, 16'd104, reset value of BAUDDIV in clk cycles per bit
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `addr`  in  16  bus address from core
- `wdata`  in  16  bus write data from core
- `we`  in  1  write strobe; the write takes effect on the rising `clk` edge
- `rdata`  out  16  combinational read data; 0 when not selected
- `rxd`  in  1  asynchronous serial input, idle high
- `txd`  out  1  serial output, idle high
- `int_vld`  out  1  level interrupt request

## Operation
- Register offsets (`addr[1:0]`):
  - 0 TXDATA: write pushes `wdata[7:0]` and is ignored when tx_busy. Reads 0.
  - 1 RXDATA: read returns `{8'h0, rx_byte}`. Any write clears rx_valid.
  - 2 STATUS: bit0 tx_busy (RO), bit1 rx_valid (RO), bit2 overrun (W1C), bit3 frame_err (W1C), bit4 rx_ie (RW), bit5 tx_ie (RW). Other bits read 0.
  - 3 BAUDDIV: RW, 16 bits. Effective divider is max(BAUDDIV, 4).
- Reads have no side effects.
- `int_vld = (rx_ie & rx_valid) | (tx_ie & ~tx_busy)`.
- TX FSM: IDLE → START → DATA(8, LSB first) → STOP → IDLE.
  - Divider is latched at START entry.
  - Each state or bit lasts exactly div cycles.
- RX path:
  - `rxd` passes through a 2-flop synchronizer.
  - A falling edge in IDLE enters START and latches the divider.
  - START checks the line at div/2 (floor). If high, it is a false start: return to IDLE with no flags.
  - DATA samples every div cycles, 8 samples, LSB first. STOP samples once more.
  - Stop bit high: rx_byte updates and rx_valid sets. Stop bit low: frame_err sets and the byte is discarded.
  - Back to IDLE immediately after the STOP sample.
- Overrun: a byte completes while rx_valid=1. overrun sets, the new byte is dropped, and the old byte is kept.
- Simultaneous RXDATA write and byte completion: the new byte is stored and rx_valid stays 1. This is not an overrun.
- Simultaneous W1C and a set event on the same flag: the set wins.
- BAUDDIV writes during a frame do not affect that frame.

## Timing
- Reset values:
  - `txd`=1, `int_vld`=0, `rdata`=0 unless selected.
  - BAUDDIV=DIV_RST, all flags and enables 0, both FSMs in IDLE.
- Reset mid-frame aborts immediately. `txd` returns high on the next edge.
- TXDATA write in cycle N:
  - tx_busy=1 and `txd`=0 from cycle N+1.
  - The frame is 10·div cycles.
  - tx_busy falls in cycle N+1+10·div.
- RX latency:
  - The falling edge reaches the synchronizer output 2 cycles after it arrives on `rxd`.
  - rx_valid rises in the cycle after the STOP sample.
- Register writes are visible on `rdata` the cycle after the write edge. `int_vld` updates in the same cycle as its sources.

## Configuration
- `YD_UART_RX_FIFO_EN` defined:
  - RX holding becomes a 4-entry FIFO. RXDATA reads the head. A write to RXDATA pops the head.
  - rx_valid means not empty. Overrun means the FIFO is full at byte completion.
  - Pop and push in the same cycle while full: both happen and overrun is not set.
- Not defined: single holding register as described above.

## Structure
- Package `yd_uart_pkg`:
  - register offsets, STATUS bit indices
  - the FSM state typedef (IDLE, START, DATA, STOP)
  - the minimum divider constant 4
- One sub-module, `yd_uart_fifo`: 4×8 synchronous FIFO, generated only under `YD_UART_RX_FIFO_EN`.
- TX and RX FSMs stay in the top module.

## Test plan
- Reset, then read BAUDDIV → 104. Read STATUS → 0. `txd`=1.
- Write BAUDDIV=8, then TXDATA=8'hA5 → `txd` carries start, bits 1,0,1,0,0,1,0,1, stop, each 8 cycles. tx_busy drops after 80 cycles. A second write during busy is ignored.
- Set rx_ie, drive 8'h3C on `rxd` at div 8 → rx_valid=1 and `int_vld`=1. RXDATA reads 16'h003C. Writing RXDATA clears both.
- Send two bytes without clearing → overrun=1 and RXDATA still holds the first byte. W1C 16'h0004 clears it.
- Stop bit driven low → frame_err=1 and rx_valid=0. A 2-cycle low glitch at div 8 → no flags set, FSM returns to IDLE.
- FIFO build: receive 5 bytes 01..05 → reads return 01..04, and overrun is set on the 5th byte.
